// File: rtl/elev_pkg.sv
// Shared definitions for the elevator call-dispatch block and its bench.
//   NFLOORS : default number of floors
//   FW      : width of a binary floor index
//   floor_t : binary floor index type
//   dir_t   : sweep direction / dispatcher state (IDLE, UP, DOWN)
package elev_pkg;

  localparam int NFLOORS = 4;
  localparam int FW      = $clog2(NFLOORS);

  typedef logic [FW-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

endpackage

// File: rtl/elev_pick.sv
// Combinational priority search over the pending-call set.
//   pending  in  : registered outstanding calls, one bit per floor
//   floorSel in  : current floor, already saturated into range
//   dir      in  : direction the target is wanted for (next state)
//   target   out : chosen floor index (binary)
//   valid    out : a target exists for the requested direction
//   above    out : some call at or above the current floor
//   below    out : some call strictly below the current floor
module elev_pick
  import elev_pkg::*;
#(
  parameter int NFLOORS = elev_pkg::NFLOORS,
  parameter int FW      = $clog2(NFLOORS)
) (
  input  logic [NFLOORS-1:0] pending,
  input  logic [FW-1:0]      floorSel,
  input  dir_t               dir,
  output logic [FW-1:0]      target,
  output logic               valid,
  output logic               above,
  output logic               below
);

  // above/below flags; independent of dir so the FSM can use them to pick dir
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      above = above | (pending[i] & (i >= int'(floorSel)));
      below = below | (pending[i] & (i <  int'(floorSel)));
    end
  end

  // Target search: nearest call in the sweep direction, the last hit in each loop wins
  always_comb begin
    target = '0;
    valid  = 1'b0;
    case (dir)
      UP: begin
        // scan downwards so the lowest index >= floor is the final assignment
        for (int i = NFLOORS - 1; i >= 0; i--) begin
          if (pending[i] && (i >= int'(floorSel))) begin
            target = FW'(i);
            valid  = 1'b1;
          end else begin
            target = target;
            valid  = valid;
          end
        end
      end
      DOWN: begin
        // scan upwards so the highest index <= floor is the final assignment
        for (int i = 0; i < NFLOORS; i++) begin
          if (pending[i] && (i <= int'(floorSel))) begin
            target = FW'(i);
            valid  = 1'b1;
          end else begin
            target = target;
            valid  = valid;
          end
        end
      end
      default: begin
        target = '0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/elev_call_dispatch.sv
// Elevator call dispatcher: latches call buttons into a pending set, runs a
// SCAN sweep over it and drives a one-hot target floor to the controller.
//   clk      in  : system clock
//   rst      in  : synchronous active-high reset
//   callBtn  in  : raw call requests, one bit per floor
//   floorSel in  : current floor from the controller (binary)
//   door     in  : controller door-open indication
//   floorBtn out : one-hot target floor, zero when idle
//   pending  out : registered outstanding calls
//   dirUp    out : sweeping up
//   busy     out : dispatcher not idle
module elev_call_dispatch
  import elev_pkg::*;
#(
  parameter int NFLOORS = elev_pkg::NFLOORS,
  parameter int FW      = $clog2(NFLOORS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NFLOORS-1:0] callBtn,
  input  logic [FW-1:0]      floorSel,
  input  logic               door,
  output logic [NFLOORS-1:0] floorBtn,
  output logic [NFLOORS-1:0] pending,
  output logic               dirUp,
  output logic               busy
);

  logic [FW-1:0]      floor_sat;
  logic               floor_ok;
  logic [NFLOORS-1:0] serve;
  logic               at_floor;
  logic [FW-1:0]      pick_target;
  logic               pick_valid;
  logic               pick_above;
  logic               pick_below;

  logic [NFLOORS-1:0] pending_d,   pending_q;
  dir_t               state_d,     state_q;
  logic [NFLOORS-1:0] floor_btn_d, floor_btn_q;
  logic               dir_up_d,    dir_up_q;
  logic               busy_d,      busy_q;

  // Out-of-range floor reports serve nothing and compare as the top floor
  always_comb begin
    if (int'(floorSel) > NFLOORS - 1) begin
      floor_sat = FW'(NFLOORS - 1);
      floor_ok  = 1'b0;
    end else begin
      floor_sat = floorSel;
      floor_ok  = 1'b1;
    end
  end

  // Serve vector and pending update; serve beats a same-cycle call
  always_comb begin
    serve = '0;
    for (int i = 0; i < NFLOORS; i++) begin
      serve[i] = door & floor_ok & (floor_sat == FW'(i));
    end
    pending_d = (pending_q | callBtn) & ~serve;
    at_floor  = pending_q[floor_sat];
  end

  elev_pick #(
    .NFLOORS (NFLOORS),
    .FW      (FW)
  ) u_pick (
    .pending  (pending_q),
    .floorSel (floor_sat),
    .dir      (state_d),
    .target   (pick_target),
    .valid    (pick_valid),
    .above    (pick_above),
    .below    (pick_below)
  );

  // Next-state logic: continue the sweep while calls remain ahead, else reverse or idle
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, UP: begin
        // upward preferred when calls exist on both sides
        if (pick_above) begin
          state_d = UP;
        end else if (pick_below) begin
          state_d = DOWN;
        end else begin
          state_d = IDLE;
        end
      end
      DOWN: begin
        // a call at the current floor keeps the downward sweep alive
        if (pick_below || at_floor) begin
          state_d = DOWN;
        end else if (pick_above) begin
          state_d = UP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: registered alongside the state from the next-state view
  always_comb begin
    if (pick_valid) begin
      floor_btn_d = {{(NFLOORS-1){1'b0}}, 1'b1} << pick_target;
    end else begin
      floor_btn_d = '0;
    end
    dir_up_d = (state_d == UP);
    busy_d   = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      state_q     <= IDLE;
      floor_btn_q <= '0;
      dir_up_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      state_q     <= state_d;
      floor_btn_q <= floor_btn_d;
      dir_up_q    <= dir_up_d;
      busy_q      <= busy_d;
    end
  end

  assign floorBtn = floor_btn_q;
  assign pending  = pending_q;
  assign dirUp    = dir_up_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_elev_call_dispatch.sv
// Directed scoreboard bench for elev_call_dispatch (NFLOORS = 4).
module tb_elev_call_dispatch;
  import elev_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   callBtn;
  floor_t       floorSel;
  logic         door;
  logic [3:0]   floorBtn;
  logic [3:0]   pending;
  logic         dirUp;
  logic         busy;

  typedef struct {
    logic [3:0] pend;
    logic [3:0] fbtn;
    logic       up;
    logic       bsy;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  elev_call_dispatch dut (
    .clk      (clk),
    .rst      (rst),
    .callBtn  (callBtn),
    .floorSel (floorSel),
    .door     (door),
    .floorBtn (floorBtn),
    .pending  (pending),
    .dirUp    (dirUp),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the state expected after the edge, then check it
  task automatic step(input logic r, input logic [3:0] cb, input logic [1:0] fs, input logic dr,
                      input logic [3:0] ep, input logic [3:0] efb, input logic eup,
                      input logic ebusy, input string tag);
    exp_t e;
    exp_t got;
    rst      = r;
    callBtn  = cb;
    floorSel = fs;
    door     = dr;
    e.pend = ep; e.fbtn = efb; e.up = eup; e.bsy = ebusy; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    n_vec++;
    assert (pending === got.pend) else begin
      n_bad++;
      $error("FAIL %s pending observed=%b expected=%b", got.tag, pending, got.pend);
    end
    n_vec++;
    assert (floorBtn === got.fbtn) else begin
      n_bad++;
      $error("FAIL %s floorBtn observed=%b expected=%b", got.tag, floorBtn, got.fbtn);
    end
    n_vec++;
    assert (dirUp === got.up) else begin
      n_bad++;
      $error("FAIL %s dirUp observed=%b expected=%b", got.tag, dirUp, got.up);
    end
    n_vec++;
    assert (busy === got.bsy) else begin
      n_bad++;
      $error("FAIL %s busy observed=%b expected=%b", got.tag, busy, got.bsy);
    end
    n_vec++;
    assert ($onehot0(floorBtn) === 1'b1) else begin
      n_bad++;
      $error("FAIL %s onehot observed=%b expected=one-hot or zero", got.tag, floorBtn);
    end
  endtask

  initial begin
    // reset held with all calls asserted
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b1111, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "reset");
    end
    // single call to floor 2, served, retired one cycle later
    step(1'b0, 4'b0100, 2'd0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, "call_latch");
    step(1'b0, 4'b0000, 2'd0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, "call_target");
    step(1'b0, 4'b0000, 2'd2, 1'b1, 4'b0000, 4'b0100, 1'b1, 1'b1, "serve2_hold");
    step(1'b0, 4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "serve2_idle");
    // sweep order: up to 3 first, then down to 0
    step(1'b0, 4'b1001, 2'd1, 1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, "sweep_latch");
    step(1'b0, 4'b0000, 2'd1, 1'b0, 4'b1001, 4'b1000, 1'b1, 1'b1, "sweep_up");
    step(1'b0, 4'b0000, 2'd3, 1'b1, 4'b0001, 4'b1000, 1'b1, 1'b1, "serve3_hold");
    step(1'b0, 4'b0000, 2'd3, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, "sweep_down");
    step(1'b0, 4'b0000, 2'd0, 1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1, "serve0_hold");
    step(1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "serve0_idle");
    // pickup: lower call above current floor overtakes the farther target
    step(1'b0, 4'b1000, 2'd1, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, "pick_latch");
    step(1'b0, 4'b0000, 2'd1, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, "pick_up3");
    step(1'b0, 4'b0100, 2'd1, 1'b0, 4'b1100, 4'b1000, 1'b1, 1'b1, "pick_inject");
    step(1'b0, 4'b0000, 2'd1, 1'b0, 4'b1100, 4'b0100, 1'b1, 1'b1, "pick_switch");
    // collision: call and serve of floor 2 in the same cycle
    step(1'b0, 4'b0000, 2'd2, 1'b1, 4'b1000, 4'b0100, 1'b1, 1'b1, "pre_collide");
    step(1'b0, 4'b0100, 2'd2, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, "collide");
    step(1'b0, 4'b0000, 2'd2, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1, "collide_after");
    step(1'b0, 4'b0000, 2'd2, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, "collide_door_off");
    // build pending=1010 in DOWN, then reset mid-run
    step(1'b0, 4'b0010, 2'd3, 1'b1, 4'b0010, 4'b1000, 1'b1, 1'b1, "serve3b_hold");
    step(1'b0, 4'b0000, 2'd3, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, "down_to1");
    step(1'b0, 4'b1000, 2'd3, 1'b0, 4'b1010, 4'b0010, 1'b0, 1'b1, "down_pend1010");
    step(1'b1, 4'b1111, 2'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "rst_mid");
    step(1'b0, 4'b0000, 2'd3, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "after_rst");
    // calls on both sides from idle: upward sweep wins
    step(1'b0, 4'b1001, 2'd2, 1'b0, 4'b1001, 4'b0000, 1'b0, 1'b0, "both_latch");
    step(1'b0, 4'b0000, 2'd2, 1'b0, 4'b1001, 4'b1000, 1'b1, 1'b1, "both_up");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/elev_call_dispatch.md
Name: elev_call_dispatch

Overview:
Request side of the elevator floor-select interface. Latches raw hall/car call buttons into a pending set. Picks one target floor with a SCAN (up/down sweep) policy and drives it as a one-hot floorBtn to the elevator controller. Watches the controller's floorSel/door outputs to retire served calls. Sits between the button inputs and the elevator controller in the top level.

Parameters:
NFLOORS, 4, number of floors; sets the width of the callBtn/floorBtn/pending vectors
FW, $clog2(NFLOORS) = 2, width of floor index (floorSel)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
callBtn  in  NFLOORS  raw call requests, one bit per floor; a 1 in any sampled cycle registers a call
floorSel  in  FW  current floor reported by the controller (binary)
door  in  1  controller door-open indication
floorBtn  out  NFLOORS  one-hot target floor to the controller; all-zero when idle
pending  out  NFLOORS  registered set of outstanding calls
dirUp  out  1  1 = sweeping up, 0 = sweeping down or idle
busy  out  1  1 when state != IDLE

Behaviour:
- One clock. Reset is synchronous, active-high, and takes priority over all other inputs. On reset: pending=0, state=IDLE, floorBtn=0, dirUp=0, busy=0.
- Reset mid-operation: all pending calls are discarded on the next edge, and callBtn is ignored while rst=1.
- Serve vector: serve[i] = door && (floorSel == i).
- Pending update on each edge: pending[i] <= (pending[i] | callBtn[i]) & ~serve[i].
  - Call and serve for the same floor in the same cycle: serve wins and the bit stays 0.
- Direction FSM. States IDLE, UP, DOWN. Evaluated on the current (registered) pending vector P and floorSel F:
  - above = any P[i] for i >= F; below = any P[i] for i < F.
  - IDLE: if above, go to UP; else if below, go to DOWN; else stay IDLE. When both above and below are set, the upward sweep is chosen.
  - UP: if above, stay UP; else if below, go to DOWN; else go to IDLE.
  - DOWN: belowEq = any P[i] for i <= F. If belowEq, stay DOWN; else if any P[i] for i > F, go to UP; else go to IDLE.
- Target selection, registered on the same edge as the state update:
  - Next state UP: lowest pending index >= F.
  - Next state DOWN: highest pending index <= F.
  - Next state IDLE: floorBtn = 0.
  - floorBtn <= onehot(target). dirUp <= (next == UP). busy <= (next != IDLE).
- Latency: callBtn sampled at edge k sets pending after k; floorBtn reflects it after edge k+1 (2 edges call-to-target).
- Retirement: after serve clears a bit, the next edge drops that floor from the target and picks the next one.
  - While door=1 at the target floor, floorBtn keeps that floor for exactly one more cycle. The controller's door-close handshake tolerates this.
- floorSel >= NFLOORS is impossible with the default parameters. For other parameter values it is treated as no floor: serve=0 and comparisons use the value saturated to NFLOORS-1.
- floorBtn is always one-hot or zero; never multi-hot.

Decomposition:
- Package elev_pkg holds: NFLOORS constant, typedef logic [FW-1:0] floor_t, typedef enum logic [1:0] {IDLE, UP, DOWN} dir_t.
- The controller and its bench share elev_pkg.
- One combinational sub-module, elev_pick:
  - Inputs: pending, floorSel, dir.
  - Outputs: target index, valid, above, below flags.
  - Isolates the priority search from the FSM and registers.

Test Plan:
- Reset: rst=1 for 4 cycles with callBtn=1111 -> pending=0000, floorBtn=0000, busy=0, dirUp=0 throughout.
- Single call: rst=0, floorSel=0, callBtn=0100 for one cycle -> pending=0100 after 1 edge, floorBtn=0100, dirUp=1, busy=1 after 2 edges. Then floorSel=2, door=1 -> pending=0000, and floorBtn=0000, busy=0 one edge later.
- Sweep order: floorSel=1, door=0, callBtn=1001 for one cycle -> state UP, floorBtn=1000. Serve floor 3 (floorSel=3, door=1) -> DOWN, floorBtn=0001, dirUp=0.
- Sweep pickup: state UP, floorSel=1, pending=1000; inject callBtn=0100 -> floorBtn switches 1000->0100 (lowest above wins).
- Collision: floorSel=2, door=1, callBtn=0100 in the same cycle -> pending[2] stays 0, floorBtn never shows 0100.
- Reset mid-run: pending=1010, state DOWN, assert rst for one cycle -> next edge pending=0000, floorBtn=0000, state IDLE.
